// File: rtl/dsp_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_arb_pkg
// Description : Shared helpers for dsp_mac_arbiter (id width, parameter legality)
// Revision    : 1.0
// ============================================================================
package dsp_arb_pkg;

    // Requester index width, never narrower than one bit.
    function automatic int calc_idw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_legal(input int w, input int n);
        return (w % 2 == 0) && (w >= 2) && (w <= 36) && (n >= 2) && (n <= 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_add_reg_mul.sv
`default_nettype none
// ============================================================================
// Module      : dsp_add_reg_mul
// Description : y = M + c with M a registered, enable-gated product a*b
// Revision    : 1.0
// ============================================================================
module dsp_add_reg_mul #(
    parameter int width = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic [width-1:0] c,
    output logic [width-1:0] y
);

    logic [width-1:0] w_prod;
    logic [width-1:0] r_m;

    // Low half of a two's-complement product is sign-agnostic.
    assign w_prod = a * b;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_m <= '0;
        end else if (en) begin
            r_m <= w_prod;
        end
    end

    assign y = r_m + c;

endmodule
`default_nettype wire

// File: rtl/dsp_mac_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mac_arbiter
// Description : Round-robin sharing of one dsp_add_reg_mul among nreq clients
// Revision    : 1.0
// ============================================================================
module dsp_mac_arbiter
    import dsp_arb_pkg::*;
#(
    parameter  int width = 8,
    parameter  int nreq  = 4,
    localparam int idw   = calc_idw(nreq)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [nreq-1:0]       req_valid,
    output logic [nreq-1:0]       req_ready,
    input  logic [nreq*width-1:0] req_a,
    input  logic [nreq*width-1:0] req_b,
    input  logic [nreq*width-1:0] req_c,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [width-1:0]      res_y,
    output logic [idw-1:0]        res_id
);

    if (!params_legal(width, nreq)) begin : g_param_check
        $error("dsp_mac_arbiter: width must be even in 2..36 and nreq in 2..8");
    end

    logic             r_m_vld;
    logic [width-1:0] r_c;
    logic [idw-1:0]   r_id;
    logic [idw-1:0]   r_rr;

    logic             w_any;
    logic             w_can_issue;
    logic             w_issue;
    logic             w_found_hi;
    logic [idw-1:0]   w_grant_hi;
    logic [idw-1:0]   w_grant_lo;
    logic [idw-1:0]   w_grant;
    logic [idw-1:0]   w_rr_next;
    logic [width-1:0] w_a;
    logic [width-1:0] w_b;
    logic [width-1:0] w_c;

    assign w_any       = |req_valid;
    assign w_can_issue = !r_m_vld || res_ready;
    assign w_issue     = w_any && w_can_issue && !reset;

    // Rotating priority: lowest valid index at or above r_rr, else lowest overall.
    always_comb begin
        w_found_hi = 1'b0;
        w_grant_hi = '0;
        w_grant_lo = '0;
        for (int i = nreq - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_grant_lo = idw'(i);
                if (idw'(i) >= r_rr) begin
                    w_grant_hi = idw'(i);
                    w_found_hi = 1'b1;
                end
            end
        end
        w_grant = w_found_hi ? w_grant_hi : w_grant_lo;
    end

    always_comb begin
        w_a       = '0;
        w_b       = '0;
        w_c       = '0;
        req_ready = '0;
        for (int i = 0; i < nreq; i++) begin
            if (w_grant == idw'(i)) begin
                w_a          = req_a[i*width +: width];
                w_b          = req_b[i*width +: width];
                w_c          = req_c[i*width +: width];
                req_ready[i] = w_issue;
            end
        end
    end

    assign w_rr_next = (w_grant == idw'(nreq - 1)) ? '0 : w_grant + idw'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_m_vld <= 1'b0;
            r_c     <= '0;
            r_id    <= '0;
            r_rr    <= '0;
        end else if (w_issue) begin
            r_m_vld <= 1'b1;
            r_c     <= w_c;
            r_id    <= w_grant;
            r_rr    <= w_rr_next;
        end else if (r_m_vld && res_ready) begin
            r_m_vld <= 1'b0;
        end
    end

    // Holding en low freezes MREG, so a stalled result stays put.
    dsp_add_reg_mul #(
        .width (width)
    ) u_dsp (
        .clock (clock),
        .reset (reset),
        .en    (w_issue),
        .a     (w_a),
        .b     (w_b),
        .c     (r_c),
        .y     (res_y)
    );

    assign res_valid = r_m_vld;
    assign res_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_mac_arbiter
// Description : Scoreboard bench for dsp_mac_arbiter with a round-robin model
// Revision    : 1.0
// ============================================================================
module tb_dsp_mac_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*W-1:0] req_c;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_y;
    logic [IDW-1:0] res_id;

    always #5 clock = ~clock;

    dsp_mac_arbiter #(
        .width (W),
        .nreq  (N)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_id    (res_id)
    );

    typedef struct {
        logic [W-1:0] y;
        int           id;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   mrr   = 0;
    bit   accepted[N];
    int   op_a[N];
    int   op_b[N];
    int   op_c[N];

    function automatic logic [W-1:0] model_y(input int a, input int b, input int c);
        int r;
        r = a * b + c;
        return r[W-1:0];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: expected outputs come from the queue and a pointer-based grant model.
    always @(negedge clock) begin
        bit   occ;
        bit   can;
        int   g;
        exp_t e;
        if (reset) begin
            check("ready_in_reset", int'(req_ready), 0);
            q.delete();
            mrr = 0;
        end else begin
            occ = (q.size() != 0);
            check("res_valid", int'(res_valid), int'(occ));
            if (occ && res_valid) begin
                check("res_y", int'(res_y), int'(q[0].y));
                check("res_id", int'(res_id), q[0].id);
            end
            can = !occ || res_ready;
            if (occ && res_ready) void'(q.pop_front());
            g = -1;
            if (can) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(mrr + k) % N]) g = (mrr + k) % N;
                end
            end
            if (g >= 0) begin
                check("req_ready_grant", int'(req_ready), 1 << g);
                e.y  = model_y(op_a[g], op_b[g], op_c[g]);
                e.id = g;
                q.push_back(e);
                mrr = (g + 1) % N;
                accepted[g] = 1'b1;
            end else begin
                check("req_ready_idle", int'(req_ready), 0);
            end
        end
    end

    task automatic set_op(input int i, input int a, input int b, input int c, input bit v);
        op_a[i] = a;
        op_b[i] = b;
        op_c[i] = c;
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
        req_c[i*W +: W] = W'(c);
        req_valid[i] = v;
    endtask

    // Presents an op on requester i and waits (bounded) for its acceptance edge.
    task automatic issue_op(input int i, input int a, input int b, input int c, output int waited);
        accepted[i] = 1'b0;
        set_op(i, a, b, c, 1'b1);
        for (int t = 1; t <= 50; t++) begin
            @(posedge clock);
            #1;
            if (accepted[i]) begin
                accepted[i] = 1'b0;
                waited = t;
                return;
            end
        end
        waited = 0;
        n_vec++;
        n_err++;
        $display("FAIL issue_timeout: req%0d not accepted within 50 cycles", i);
    endtask

    function automatic int rnd();
        return int'($urandom_range(0, 6)) - 3;
    endfunction

    task automatic drive(input int cycles, input int ready_pct, input bit hold_all);
        repeat (cycles) begin
            @(posedge clock);
            #1;
            res_ready = (int'($urandom_range(0, 99)) < ready_pct);
            for (int i = 0; i < N; i++) begin
                if (accepted[i]) begin
                    accepted[i] = 1'b0;
                    if (hold_all || $urandom_range(0, 3) != 0)
                        set_op(i, rnd(), rnd(), hold_all ? i + 1 : rnd(), 1'b1);
                    else
                        req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if (hold_all || $urandom_range(0, 1) != 0)
                        set_op(i, rnd(), rnd(), hold_all ? i + 1 : rnd(), 1'b1);
                end else if (!hold_all && $urandom_range(0, 31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        int w;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) accepted[i] = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_id", int'(res_id), 0);
        check("rst_req_ready", int'(req_ready), 0);
        @(posedge clock);
        #1;

        // Single op
        issue_op(0, 3, 4, 5, w);
        req_valid[0] = 1'b0;
        check("single_valid", int'(res_valid), 1);
        check("single_y", int'(res_y), 17);
        check("single_id", int'(res_id), 0);

        // Negative operands
        issue_op(0, -2, 3, 1, w);
        req_valid[0] = 1'b0;
        check("neg_y", int'(res_y), 'hFB);

        // Back-to-back on requester 1
        issue_op(1, 1, 2, 0, w);
        issue_op(1, 2, 3, 1, w);
        check("b2b_latency2", w, 1);
        issue_op(1, 3, 3, 3, w);
        check("b2b_latency3", w, 1);
        req_valid[1] = 1'b0;
        check("b2b_last_y", int'(res_y), 12);

        // Backpressure: stall five cycles with a competitor waiting
        @(posedge clock);
        #1;
        res_ready = 1'b0;
        issue_op(0, 2, 3, 4, w);
        req_valid[0] = 1'b0;
        set_op(2, 1, 1, 1, 1'b1);
        repeat (5) begin
            check("bp_stable_y", int'(res_y), 10);
            check("bp_no_ready", int'(req_ready), 0);
            @(posedge clock);
            #1;
        end
        check("bp_held_grant", int'(accepted[2]), 0);
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_release_grant", int'(accepted[2]), 1);
        accepted[2] = 1'b0;
        req_valid[2] = 1'b0;

        // Reset mid-flight, then pointer restarts at 0
        @(posedge clock);
        #1;
        issue_op(2, 1, 2, 3, w);
        req_valid[2] = 1'b0;
        reset = 1'b1;
        set_op(3, 2, 2, 2, 1'b1);
        set_op(1, 1, 3, 0, 1'b1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mid_rst_valid", int'(res_valid), 0);
        check("mid_rst_id", int'(res_id), 0);
        @(posedge clock);
        #1;
        check("post_rst_grant1", int'(accepted[1]), 1);
        check("post_rst_grant3", int'(accepted[3]), 0);
        req_valid = '0;
        for (int i = 0; i < N; i++) accepted[i] = 1'b0;

        // Round robin with everyone requesting, then randomized traffic
        drive(16, 100, 1'b1);
        drive(3000, 75, 1'b0);

        req_valid = '0;
        res_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("drain_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_mac_arbiter.md
# dsp_mac_arbiter

Round-robin arbiter and sequencer that shares one `dsp_add_reg_mul` instance (y = M + C, M registered, C combinational) among `nreq` requesters. It issues a/b into the multiplier register, aligns each operation's c one cycle later, and returns the result tagged with the requester index. The result port is stall-capable. The block sits between several compute clients and a single DSP48E2 slice.

## Interface
- `width`, 8: operand/result width; even, 2..36, same constraint as `dsp_add_reg_mul`.
- `nreq`, 4: number of requesters, 2..8.
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high; also drives the DSP `reset`.
- `req_valid`  in  nreq  per-requester operation valid.
- `req_ready`  out  nreq  per-requester grant/accept; one-hot or zero.
- `req_a`  in  nreq*width  packed operand a; requester i at bits [i*width +: width].
- `req_b`  in  nreq*width  packed operand b, same packing.
- `req_c`  in  nreq*width  packed addend c, same packing.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  downstream accept.
- `res_y`  out  width  DSP result y.
- `res_id`  out  idw  index of the originating requester; idw = max(1, clog2(nreq)).

## Operation
- Stage M: a single "M slot" holds the operation in the DSP MREG. State is `m_vld`, `c_q` (width), `id_q` (idw).
- `can_issue = !m_vld || (res_valid && res_ready)`.
- Arbitration (combinational): starting at pointer `rr`, grant the first i (ascending, wrapping) with `req_valid[i]`. `req_ready[i]` = 1 only for the grantee, and only when `can_issue`.
- Issue (any `req_valid` and `can_issue`):
  - DSP `a`/`b` = grantee's operands, DSP `en` = 1.
  - `c_q` <= grantee's c; `id_q` <= grant index; `m_vld` <= 1.
  - `rr` <= grant+1 mod nreq.
- No issue: DSP `en` = 0, so MREG holds and a stalled result stays stable. DSP a/b are don't-care.
  - If the result fires, `m_vld` <= 0.
  - `rr` is unchanged.
- DSP `c` is always driven from `c_q`. `res_y` = DSP `y`, `res_id` = `id_q`, `res_valid` = `m_vld`.
- Issue and fire in the same cycle: the slot is refilled and `m_vld` stays 1. This gives back-to-back throughput of 1 op/cycle.
- Arithmetic: `res_y` is exactly the `dsp_add_reg_mul` function of the issued (a, b) and c_q. For operand magnitudes < 2^(width/2-2), this equals (a*b + c) mod 2^width, signed.
- Requesters must hold a/b/c stable while valid and unaccepted. Dropping `req_valid` before acceptance is permitted and is simply not granted.

## Timing
- Reset values: `m_vld`=0, `rr`=0, `c_q`=0, `id_q`=0. Outputs during and after reset: `res_valid`=0, `req_ready`=0, `res_id`=0. The DSP MREG is cleared via `reset`.
- Latency: accept at edge t → `res_valid`=1 in cycle t+1 (after edge t), with y and id valid in that same cycle.
- Stall: while `res_valid && !res_ready`, all `req_ready`=0, and `res_y`/`res_id` stay constant.
- Fairness: a continuously requesting requester is granted within nreq issues.
- Reset mid-operation: an in-flight result is discarded and the grant pointer returns to 0. There is no output glitch in the reset cycle, because `res_valid` is registered.
- Single requester active: granted every cycle while `res_ready`=1. `rr` still advances past it.

## Structure
- Package `dsp_arb_pkg`: `idw` calculation function and parameter-legality checks (`width` even ≤36, 2 ≤ `nreq` ≤ 8).
- Sub-module: the existing `dsp_add_reg_mul`, instantiated once, with `clock`/`reset` wired through and `en` = issue.
- Arbiter logic (rotating priority encoder) stays inline. It is small enough that a separate `rr_arbiter` module is not needed.

## Test plan
- Single op: reset; req0 a=3, b=4, c=5 → `req_ready[0]`=1 for one cycle; next cycle `res_valid`=1, `res_y`=17, `res_id`=0.
- Back-to-back: req1 streams (1,2,0), (2,3,1), (3,3,3) with `res_ready`=1 → results 2, 7, 12 on consecutive cycles; `req_ready[1]` high for 3 consecutive cycles.
- Round robin: all four request continuously with distinct c → `res_id` sequence 0,1,2,3,0,1…; no requester waits more than 4 issues.
- Backpressure: hold `res_ready`=0 for 5 cycles after one issue → `res_y` stable, all `req_ready`=0; on release the result fires and the next grant issues in the same cycle.
- Negative operands: a=-2, b=3, c=1 at width 8 → `res_y`=8'hFB.
- Reset mid-flight: assert reset the cycle after issue → `res_valid`=0 next cycle; first post-reset grant goes to the lowest valid index starting from 0.
